// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: self-timed stimulus sweep and truth-table capture
// for a 4-input, 2-output combinational block. Vectors 0..15 are driven on
// {a,b,c,d} in ascending order, each held HOLD_CYCLES clocks, and f1/f2 are
// sampled on the last clock of each hold window into result_f1/result_f2.
// Optional build macro TRUTH_TABLE_COMPARE_EN adds comparison against
// EXP_F1/EXP_F2 with an error counter and a sticky mismatch flag.
module truth_table_sequencer #(
  parameter int HOLD_CYCLES = 20
`ifdef TRUTH_TABLE_COMPARE_EN
  ,
  parameter logic [15:0] EXP_F1 = 16'h0000,
  parameter logic [15:0] EXP_F2 = 16'h0000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f1,
  input  logic        f2,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] result_f1,
  output logic [15:0] result_f2
`ifdef TRUTH_TABLE_COMPARE_EN
  ,
  output logic        mismatch,
  output logic [5:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] idx;
  logic [7:0] hold_cnt;
  logic       sample;
  logic       last_vec;

  // idx is forced back to zero outside APPLY, so it can drive the vector
  // outputs directly and they read 0000 in IDLE and DONE.
  assign {a, b, c, d} = idx;
  assign busy         = (state == APPLY);
  assign done         = (state == DONE);
  assign sample       = (state == APPLY) && (hold_cnt == HOLD_LAST);
  assign last_vec     = (idx == 4'd15);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; start only matters in IDLE, DONE always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = APPLY;
      APPLY:   if (sample && last_vec) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Vector index, hold timer and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 4'd0;
      hold_cnt  <= 8'd0;
      result_f1 <= 16'h0000;
      result_f2 <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= 4'd0;
            hold_cnt  <= 8'd0;
            result_f1 <= 16'h0000;
            result_f2 <= 16'h0000;
          end
        end
        APPLY: begin
          if (sample) begin
            hold_cnt       <= 8'd0;
            result_f1[idx] <= f1;
            result_f2[idx] <= f2;
            idx            <= last_vec ? 4'd0 : idx + 4'd1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          idx      <= 4'd0;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef TRUTH_TABLE_COMPARE_EN
  logic [5:0] err_next;

  assign err_next = err_count + 6'(f1 != EXP_F1[idx]) + 6'(f2 != EXP_F2[idx]);

  // Error accumulation per sample; mismatch reflects the total including the final vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 6'd0;
      mismatch  <= 1'b0;
    end else if (state == IDLE && start) begin
      err_count <= 6'd0;
      mismatch  <= 1'b0;
    end else if (sample) begin
      err_count <= err_next;
      if (last_vec) mismatch <= (err_next != 6'd0);
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed bench for truth_table_sequencer.
// dut2 runs HOLD_CYCLES=2 with f1=a&b, f2=c|d (f1 can be forced to 0);
// dut1 runs HOLD_CYCLES=1 with f1=a^b^c^d, f2=0. Edge numbering below
// counts the edge that accepts start as edge 1.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start2, start1, zero_f1;

  logic a2, b2, c2, d2, busy2, done2;
  logic [15:0] res_f1_2, res_f2_2;
  logic a1, b1, c1, d1, busy1, done1;
  logic [15:0] res_f1_1, res_f2_1;
  logic f1_2, f2_2, f1_1, f2_1;
`ifdef TRUTH_TABLE_COMPARE_EN
  logic mm2, mm1;
  logic [5:0] err2, err1;
`endif

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  assign f1_2 = zero_f1 ? 1'b0 : (a2 & b2);
  assign f2_2 = c2 | d2;
  assign f1_1 = a1 ^ b1 ^ c1 ^ d1;
  assign f2_1 = 1'b0;

  truth_table_sequencer #(
    .HOLD_CYCLES(2)
`ifdef TRUTH_TABLE_COMPARE_EN
    , .EXP_F1(16'hF000), .EXP_F2(16'hEEEE)
`endif
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .f1(f1_2), .f2(f2_2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
    .result_f1(res_f1_2), .result_f2(res_f2_2)
`ifdef TRUTH_TABLE_COMPARE_EN
    , .mismatch(mm2), .err_count(err2)
`endif
  );

  truth_table_sequencer #(
    .HOLD_CYCLES(1)
`ifdef TRUTH_TABLE_COMPARE_EN
    , .EXP_F1(16'h6996), .EXP_F2(16'h0000)
`endif
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f1(f1_1), .f2(f2_1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .result_f1(res_f1_1), .result_f2(res_f2_1)
`ifdef TRUTH_TABLE_COMPARE_EN
    , .mismatch(mm1), .err_count(err1)
`endif
  );

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Drive both start inputs at a falling edge so they are stable at the next rising edge
  task automatic applyStimulus(input logic s2, input logic s1);
    @(negedge clk);
    start2 = s2;
    start1 = s1;
  endtask

  // One start pulse on dut2, then per-cycle vector/busy checks and final results
  task automatic sweepHold2(input logic [15:0] want_f1, input logic [15:0] want_f2,
                            input logic [5:0] want_err, input logic want_mm);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
`ifdef TRUTH_TABLE_COMPARE_EN
    checkOutput("err_clear_on_start", 32'(err2), 32'd0);
`endif
    // now just after edge 1; vector n/2 is shown after edges 1..32
    for (int n = 0; n < 32; n++) begin
      checkOutput("h2_vector", 32'({a2, b2, c2, d2}), 32'(n / 2));
      checkOutput("h2_busy", 32'({busy2, done2}), 32'b10);
      @(negedge clk);
    end
    // after edge 33
    checkOutput("h2_done_pulse", 32'({busy2, done2}), 32'b01);
    checkOutput("h2_done_vector", 32'({a2, b2, c2, d2}), 32'd0);
    checkOutput("h2_result_f1", 32'(res_f1_2), 32'(want_f1));
    checkOutput("h2_result_f2", 32'(res_f2_2), 32'(want_f2));
`ifdef TRUTH_TABLE_COMPARE_EN
    checkOutput("h2_err_count", 32'(err2), 32'(want_err));
    checkOutput("h2_mismatch", 32'(mm2), 32'(want_mm));
`else
    if (want_err != 6'd0 && want_mm == 1'b0) tests_run = tests_run + 0;
`endif
    @(negedge clk);
    checkOutput("h2_done_single", 32'({busy2, done2}), 32'b00);
    checkOutput("h2_results_hold", 32'({res_f1_2, res_f2_2}), {want_f1, want_f2});
  endtask

  initial begin
    int done_cnt;
    rst     = 1'b1;
    start2  = 1'b0;
    start1  = 1'b0;
    zero_f1 = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_outputs2", 32'({a2, b2, c2, d2, busy2, done2}), 32'd0);
    checkOutput("rst_results2", 32'({res_f1_2, res_f2_2}), 32'd0);
    checkOutput("rst_outputs1", 32'({a1, b1, c1, d1, busy1, done1}), 32'd0);
`ifdef TRUTH_TABLE_COMPARE_EN
    checkOutput("rst_compare", 32'({mm2, err2}), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // start held high through a sweep and DONE: one done pulse, then a new sweep
    done_cnt = 0;
    applyStimulus(1'b1, 1'b0);
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      if (done2) done_cnt++;
      if (n == 33) checkOutput("held_done_edge33", 32'(done2), 32'd1);
      if (n == 34) checkOutput("held_idle_gap", 32'({busy2, done2}), 32'b00);
      if (n == 35) checkOutput("held_restart", 32'({busy2, a2, b2, c2, d2}), 32'b10000);
    end
    checkOutput("held_done_count", 32'(done_cnt), 32'd1);
    checkOutput("held_results", 32'({res_f1_2, res_f2_2}), 32'h0000_0000);
    start2 = 1'b0;

    // Second sweep started at edge 35; vector 7 is shown after edge 49
    repeat (14) @(negedge clk);
    checkOutput("mid_vector7", 32'({a2, b2, c2, d2}), 32'd7);
    checkOutput("mid_partial_f2", 32'(res_f2_2), 32'h006E);

    // Asynchronous reset mid-sweep
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_outputs", 32'({a2, b2, c2, d2, busy2, done2}), 32'd0);
    checkOutput("async_rst_results", 32'({res_f1_2, res_f2_2}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_idle", 32'({busy2, done2}), 32'd0);

    // Full sweep after reset, then the same sweep with f1 tied low
    sweepHold2(16'hF000, 16'hEEEE, 6'd0, 1'b0);
    zero_f1 = 1'b1;
    sweepHold2(16'h0000, 16'hEEEE, 6'd4, 1'b1);
    zero_f1 = 1'b0;

    // HOLD_CYCLES=1 parity sweep on dut1: vector k-1 after edge k, done after edge 17
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      checkOutput("h1_vector", 32'({busy1, done1, a1, b1, c1, d1}), 32'({2'b10, 4'(k - 1)}));
      @(negedge clk);
    end
    checkOutput("h1_done_edge17", 32'({busy1, done1}), 32'b01);
    checkOutput("h1_result_f1", 32'(res_f1_1), 32'h6996);
    checkOutput("h1_result_f2", 32'(res_f2_1), 32'h0000);
`ifdef TRUTH_TABLE_COMPARE_EN
    checkOutput("h1_compare", 32'({mm1, err1}), 32'd0);
`endif
    @(negedge clk);
    checkOutput("h1_done_single", 32'(done1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
